// File: rtl/divider_pkg.sv
// Shared definitions for the 16/8 unsigned sequential divider:
// operand widths, iteration count, divide-by-zero quotient and FSM states.
package divider_pkg;
    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int DIV_ITER   = 16;
    localparam int CNT_W      = $clog2(DIV_ITER);

    // Quotient reported when the divisor is zero (all ones, like hardware dividers usually do)
    localparam logic [DIVIDEND_W-1:0] DBZ_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/eight_bit_unsigned_sequential_divider_if.sv
// Handshake/data bundle between a controller (master) and the divider (slave).
interface eight_bit_unsigned_sequential_divider_if;
    import divider_pkg::*;

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  q_ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, q_ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, q_ovf
    );
endinterface

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and emit the corresponding quotient bit.
module divider_step
    import divider_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] rem_o,
    output logic                 qbit_o
);
    // Partial remainder needs one extra bit before the compare
    logic [DIVISOR_W:0] trial_rem;
    logic [DIVISOR_W:0] divisor_ext;

    assign trial_rem   = {rem_i, bit_i};
    assign divisor_ext = {1'b0, divisor_i};
    assign qbit_o      = (trial_rem >= divisor_ext);
    // After a successful subtract the result is below the divisor, so 8 bits suffice
    assign rem_o       = qbit_o ? DIVISOR_W'(trial_rem - divisor_ext)
                                : trial_rem[DIVISOR_W-1:0];
endmodule

// File: rtl/eight_bit_unsigned_sequential_divider.sv
// 16-bit by 8-bit unsigned restoring divider, one quotient bit per clock.
// Optional quotient-overflow flag (quotient > 255) built when the macro
// DIVIDER_QUOT_OVF_EN is defined; otherwise q_ovf is tied low.
module eight_bit_unsigned_sequential_divider
    import divider_pkg::*;
(
    input  logic clk,
    input  logic reset,
    eight_bit_unsigned_sequential_divider_if.slave bus
);
    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIVIDEND_W-1:0] work_q;      // dividend bits shift out, quotient bits shift in
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dvsr_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  remo_q;
    logic                  dbz_q;

    logic [DIVISOR_W-1:0]  rem_d;
    logic                  qbit_d;
    logic [DIVIDEND_W-1:0] quot_d;
    logic                  last_step;

    divider_step u_step (
        .rem_i     (rem_q),
        .bit_i     (work_q[DIVIDEND_W-1]),
        .divisor_i (dvsr_q),
        .rem_o     (rem_d),
        .qbit_o    (qbit_d)
    );

    assign quot_d    = {work_q[DIVIDEND_W-2:0], qbit_d};
    assign last_step = (cnt_q == CNT_W'(DIV_ITER - 1));

`ifdef DIVIDER_QUOT_OVF_EN
    logic q_ovf_q;
`endif

    // FSM, iteration datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_QUOT_OVF_EN
            q_ovf_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvsr_q <= bus.divisor;
                        work_q <= bus.dividend;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        if (bus.divisor != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            // Zero divisor: skip the iterations and report at once
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quot_q  <= DBZ_QUOT;
                            remo_q  <= bus.dividend[DIVISOR_W-1:0];
                            dbz_q   <= 1'b1;
`ifdef DIVIDER_QUOT_OVF_EN
                            q_ovf_q <= |DBZ_QUOT[DIVIDEND_W-1:DIVISOR_W];
`endif
                        end
                    end else if (state_q == DONE) begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    work_q <= quot_d;
                    rem_q  <= rem_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_step) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= quot_d;
                        remo_q  <= rem_d;
                        dbz_q   <= 1'b0;
`ifdef DIVIDER_QUOT_OVF_EN
                        q_ovf_q <= |quot_d[DIVIDEND_W-1:DIVISOR_W];
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;
`ifdef DIVIDER_QUOT_OVF_EN
    assign bus.q_ovf       = q_ovf_q;
`else
    assign bus.q_ovf       = 1'b0;
`endif
endmodule

// File: tb/tb_eight_bit_unsigned_sequential_divider.sv
// Self-checking bench for the sequential divider: table of vectors plus
// hand-written handshake / reset sequences, results checked via a scoreboard.
module tb_eight_bit_unsigned_sequential_divider;
`ifdef DIVIDER_QUOT_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    eight_bit_unsigned_sequential_divider_if bus_if ();

    eight_bit_unsigned_sequential_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] q;
        logic [7:0]  r;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a one-cycle start; optionally record the expected result
    task automatic issue(input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [15:0] q, input logic [7:0] r, input bit push);
        exp_t e;
        bus_if.dividend = dvd;
        bus_if.divisor  = dvs;
        bus_if.start    = 1'b1;
        if (push) begin
            e.q        = q;
            e.r        = r;
            e.dbz      = (dvs == 8'd0);
            e.ovf      = OVF_EN ? |q[15:8] : 1'b0;
            e.done_cyc = cyc + ((dvs == 8'd0) ? 1 : 17);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation
    always begin
        exp_t e;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (bus_if.done === 1'b1) begin
            check("done_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("quotient",    {16'd0, bus_if.quotient},  {16'd0, e.q});
                check("remainder",   {24'd0, bus_if.remainder}, {24'd0, e.r});
                check("div_by_zero", {31'd0, bus_if.div_by_zero}, {31'd0, e.dbz});
                check("q_ovf",       {31'd0, bus_if.q_ovf},     {31'd0, e.ovf});
                check("done_cycle",  cyc,                       e.done_cyc);
                $display("[TB] result cyc=%0d q=%0d r=%0d dbz=%0b ovf=%0b",
                         cyc, bus_if.quotient, bus_if.remainder, bus_if.div_by_zero, bus_if.q_ovf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   c;
        int   a;
        int   b;

        vecs[0] = '{dvd: 16'd200,   dvs: 8'd7,   q: 16'd28,    r: 8'd4};
        vecs[1] = '{dvd: 16'd65025, dvs: 8'd255, q: 16'd255,   r: 8'd0};
        vecs[2] = '{dvd: 16'd65535, dvs: 8'd255, q: 16'd257,   r: 8'd0};
        vecs[3] = '{dvd: 16'h1234,  dvs: 8'd0,   q: 16'hFFFF,  r: 8'h34};
        vecs[4] = '{dvd: 16'd1000,  dvs: 8'd10,  q: 16'd100,   r: 8'd0};
        vecs[5] = '{dvd: 16'd5,     dvs: 8'd9,   q: 16'd0,     r: 8'd5};
        vecs[6] = '{dvd: 16'd65535, dvs: 8'd1,   q: 16'd65535, r: 8'd0};
        vecs[7] = '{dvd: 16'd255,   dvs: 8'd16,  q: 16'd15,    r: 8'd15};

        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
        reset = 1'b1;
        idle_cycles(3);
        check("rst_busy",  {31'd0, bus_if.busy}, 32'd0);
        check("rst_done",  {31'd0, bus_if.done}, 32'd0);
        check("rst_quot",  {16'd0, bus_if.quotient}, 32'd0);
        check("rst_rem",   {24'd0, bus_if.remainder}, 32'd0);
        check("rst_dbz",   {31'd0, bus_if.div_by_zero}, 32'd0);
        check("rst_ovf",   {31'd0, bus_if.q_ovf}, 32'd0);
        reset = 1'b0;
        idle_cycles(2);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, 1'b1);
            wait_drain(40);
        end

        // Busy window of a normal divide
        c = cyc;
        issue(16'd200, 8'd7, 16'd28, 8'd4, 1'b1);
        check("busy_first", {31'd0, bus_if.busy}, 32'd1);
        idle_cycles(15);
        check("busy_last", {31'd0, bus_if.busy}, 32'd1);
        idle_cycles(1);
        check("busy_after", {31'd0, bus_if.busy}, 32'd0);
        wait_drain(40);

        // Divide by zero never raises busy
        issue(16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1);
        check("dbz_busy", {31'd0, bus_if.busy}, 32'd0);
        wait_drain(10);

        // Start pulse mid-run with new operands is ignored
        issue(16'd200, 8'd7, 16'd28, 8'd4, 1'b1);
        idle_cycles(4);
        bus_if.dividend = 16'd999;
        bus_if.divisor  = 8'd3;
        bus_if.start    = 1'b1;
        idle_cycles(1);
        bus_if.start    = 1'b0;
        wait_drain(40);
        idle_cycles(20);

        // Start held high: back-to-back results every 17 cycles
        c = cyc;
        bus_if.dividend = 16'd1000;
        bus_if.divisor  = 8'd10;
        bus_if.start    = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            exp_t e;
            e.q = 16'd100; e.r = 8'd0; e.dbz = 1'b0; e.ovf = 1'b0;
            e.done_cyc = c + 17 * k;
            sb.push_back(e);
        end
        idle_cycles(35);
        bus_if.start = 1'b0;
        wait_drain(60);
        idle_cycles(20);

        // Reset in the middle of a run: outputs clear, no done pulse
        issue(16'd65025, 8'd255, 16'd0, 8'd0, 1'b0);
        idle_cycles(8);
        reset = 1'b1;
        idle_cycles(1);
        check("mid_rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus_if.done}, 32'd0);
        check("mid_rst_quot", {16'd0, bus_if.quotient}, 32'd0);
        check("mid_rst_rem",  {24'd0, bus_if.remainder}, 32'd0);
        check("mid_rst_dbz",  {31'd0, bus_if.div_by_zero}, 32'd0);
        check("mid_rst_ovf",  {31'd0, bus_if.q_ovf}, 32'd0);
        reset = 1'b0;
        idle_cycles(25);
        issue(16'd200, 8'd7, 16'd28, 8'd4, 1'b1);
        wait_drain(40);

        // Multiplier inverse: random 8x8 products divided by one factor
        for (int i = 0; i < 100; i++) begin
            a = int'($urandom_range(1, 255));
            b = int'($urandom_range(0, 255));
            issue(16'(a * b), 8'(a), 16'(b), 8'd0, 1'b1);
            wait_drain(40);
        end

        idle_cycles(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
